// File: rtl/vending_machine_n_if.sv
// Coin/selection/vend/change signal bundle between the front end and vending_machine_n.
// master = coin acceptor / keypad side, slave = the vending controller.
interface vending_machine_n_if #(
  parameter int CREDIT_W = 8,
  parameter int SEL_W    = 2
);
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                sel_valid;
  logic [SEL_W-1:0]    sel;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic                dispense;
  logic [SEL_W-1:0]    dispense_id;
  logic                coin_reject;
  logic                sel_denied;
  logic                change_valid;
  logic [1:0]          change_type;
  logic                busy;

  modport master (
    output coin_valid, coin_type, sel_valid, sel, cancel,
    input  credit, dispense, dispense_id, coin_reject, sel_denied,
           change_valid, change_type, busy
  );

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel, cancel,
    output credit, dispense, dispense_id, coin_reject, sel_denied,
           change_valid, change_type, busy
  );
endinterface

// File: rtl/vending_machine_n.sv
// Multi-product vending controller: coin credit, priced selection, one-cycle dispense.
// Define VEND_CHANGE_EN to return remainder/cancelled credit as greedy change; otherwise remainder stays as credit.
module vending_machine_n #(
  parameter int CREDIT_W   = 8,
  parameter int N_PROD     = 4,
  parameter int PRICE_BASE = 5,
  parameter int PRICE_STEP = 5,
  parameter int COIN_V0    = 1,
  parameter int COIN_V1    = 2,
  parameter int COIN_V2    = 5,
  parameter int COIN_V3    = 10,
  parameter int MAX_CREDIT = 50
) (
  input logic               clk,
  input logic               reset,
  vending_machine_n_if.slave bus
);

  localparam int SEL_W = $clog2(N_PROD);
  localparam int SUM_W = CREDIT_W + 1;
  localparam int N_SEL = 1 << SEL_W;

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_e;

  function automatic logic [N_SEL-1:0] sel_ok_mask();
    logic [N_SEL-1:0] m;
    m = '0;
    for (int i = 0; i < N_SEL; i++) m[i] = (i < N_PROD);
    return m;
  endfunction

  // Codes beyond N_PROD-1 are representable in sel but are not products.
  localparam logic [N_SEL-1:0] SEL_OK = sel_ok_mask();

  function automatic credit_t coin_value(input logic [1:0] t);
    case (t)
      2'd0:    return credit_t'(COIN_V0);
      2'd1:    return credit_t'(COIN_V1);
      2'd2:    return credit_t'(COIN_V2);
      default: return credit_t'(COIN_V3);
    endcase
  endfunction

  state_e            state_q, state_d;
  credit_t           credit_q, credit_d;
  logic              dispense_q, dispense_d;
  logic [SEL_W-1:0]  dispense_id_q, dispense_id_d;
  logic              coin_reject_q, coin_reject_d;
  logic              sel_denied_q, sel_denied_d;
  logic              change_valid_q, change_valid_d;
  logic [1:0]        change_type_q, change_type_d;

  credit_t           coin_val;
  credit_t           price;
  logic [SUM_W-1:0]  coin_sum;
  logic              coin_fits;
  logic              sel_ok;

  assign coin_val  = coin_value(bus.coin_type);
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits = (coin_sum <= SUM_W'(MAX_CREDIT));
  assign price     = credit_t'(PRICE_BASE) + credit_t'(PRICE_STEP) * credit_t'(bus.sel);
  assign sel_ok    = SEL_OK[bus.sel] && (credit_q >= price);

`ifdef VEND_CHANGE_EN
  // Greedy change: largest denomination not exceeding the remaining credit.
  function automatic logic [1:0] greedy_type(input credit_t c);
    if (c >= credit_t'(COIN_V3)) return 2'd3;
    if (c >= credit_t'(COIN_V2)) return 2'd2;
    if (c >= credit_t'(COIN_V1)) return 2'd1;
    return 2'd0;
  endfunction

  logic [1:0] chg_type;
  credit_t    chg_val;
  assign chg_type = greedy_type(credit_q);
  assign chg_val  = coin_value(chg_type);
`else
  // Cancel has no effect without a change hopper.
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
`endif

  always_comb begin
    // NOTE: every _d signal gets its default before the case so no path can infer a latch.
    state_d        = state_q;
    credit_d       = credit_q;
    dispense_d     = 1'b0;
    dispense_id_d  = '0;
    coin_reject_d  = 1'b0;
    sel_denied_d   = 1'b0;
    change_valid_d = 1'b0;
    change_type_d  = '0;

    case (state_q)
      IDLE: begin
        if (bus.coin_valid) begin
          if (coin_fits) begin
            credit_d = credit_q + coin_val;
            state_d  = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        if (bus.sel_valid) sel_denied_d = 1'b1;
      end

      CREDIT: begin
`ifdef VEND_CHANGE_EN
        if (bus.cancel) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          change_type_d  = chg_type;
          credit_d       = credit_q - chg_val;
          coin_reject_d  = bus.coin_valid;
        end else
`endif
        if (bus.sel_valid) begin
          // Selection is judged on pre-coin credit; a coin in the same cycle is refused.
          coin_reject_d = bus.coin_valid;
          if (sel_ok) begin
            credit_d      = credit_q - price;
            dispense_d    = 1'b1;
            dispense_id_d = bus.sel;
            state_d       = VEND;
          end else begin
            sel_denied_d = 1'b1;
          end
        end else if (bus.coin_valid) begin
          if (coin_fits) credit_d = credit_q + coin_val;
          else           coin_reject_d = 1'b1;
        end
      end

      VEND: begin
        coin_reject_d = bus.coin_valid;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
`ifdef VEND_CHANGE_EN
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          change_type_d  = chg_type;
          credit_d       = credit_q - chg_val;
`else
          state_d = CREDIT;
`endif
        end
      end

`ifdef VEND_CHANGE_EN
      CHANGE: begin
        coin_reject_d = bus.coin_valid;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          change_valid_d = 1'b1;
          change_type_d  = chg_type;
          credit_d       = credit_q - chg_val;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      dispense_q     <= 1'b0;
      dispense_id_q  <= '0;
      coin_reject_q  <= 1'b0;
      sel_denied_q   <= 1'b0;
      change_valid_q <= 1'b0;
      change_type_q  <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      dispense_q     <= dispense_d;
      dispense_id_q  <= dispense_id_d;
      coin_reject_q  <= coin_reject_d;
      sel_denied_q   <= sel_denied_d;
      change_valid_q <= change_valid_d;
      change_type_q  <= change_type_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.dispense     = dispense_q;
  assign bus.dispense_id  = dispense_id_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.sel_denied   = sel_denied_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_type  = change_type_q;
  assign bus.busy         = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vending_machine_n.sv
// Directed table-driven bench for vending_machine_n (default parameters), plus reset corner sequences.
// Expectations follow whichever VEND_CHANGE_EN build is compiled.
module tb_vending_machine_n;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  vending_machine_n_if #(.CREDIT_W(8), .SEL_W(2)) bus ();

  vending_machine_n dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {credit, dispense, dispense_id, coin_reject, sel_denied, change_valid, change_type, busy}
  logic [16:0] obs;
  assign obs = {bus.credit, bus.dispense, bus.dispense_id, bus.coin_reject,
                bus.sel_denied, bus.change_valid, bus.change_type, bus.busy};

  typedef struct {
    logic       cv;
    logic [1:0] ct;
    logic       sv;
    logic [1:0] s;
    logic       cn;
    logic [7:0] credit;
    logic       disp;
    logic [1:0] id;
    logic       rej;
    logic       den;
    logic       chv;
    logic [1:0] cht;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cv, input logic [1:0] ct, input logic sv, input logic [1:0] s,
                     input logic cn, input logic [7:0] credit, input logic disp, input logic [1:0] id,
                     input logic rej, input logic den, input logic chv, input logic [1:0] cht,
                     input logic busy);
    vec_t v;
    v = '{cv, ct, sv, s, cn, credit, disp, id, rej, den, chv, cht, busy};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [1:0] ct, input logic sv, input logic [1:0] s,
                       input logic cn);
    bus.coin_valid = cv;
    bus.coin_type  = ct;
    bus.sel_valid  = sv;
    bus.sel        = s;
    bus.cancel     = cn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic cv_seen = 1'b0;
  always @(negedge clk) if (bus.change_valid === 1'b1) cv_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // cv ct sv s cn | credit disp id rej den chv cht busy
    add(0,0,0,0,0,  0, 0,0,0,0,0,0,0);
    add(0,0,1,1,0,  0, 0,0,0,1,0,0,0);   // select while idle
    add(1,3,0,0,0, 10, 0,0,0,0,0,0,0);
    add(1,2,0,0,0, 15, 0,0,0,0,0,0,0);
    add(0,0,1,2,0,  0, 1,2,0,0,0,0,1);   // exact price
    add(0,0,0,0,0,  0, 0,0,0,0,0,0,0);
    add(1,3,0,0,0, 10, 0,0,0,0,0,0,0);
    add(1,3,0,0,0, 20, 0,0,0,0,0,0,0);
    add(0,0,1,0,0, 15, 1,0,0,0,0,0,1);
`ifdef VEND_CHANGE_EN
    add(0,0,0,0,0,  5, 0,0,0,0,1,3,1);
    add(0,0,0,0,0,  0, 0,0,0,0,1,2,1);
    add(0,0,0,0,0,  0, 0,0,0,0,0,0,0);
`else
    add(0,0,0,0,0, 15, 0,0,0,0,0,0,0);
    add(0,0,1,2,0,  0, 1,2,0,0,0,0,1);
    add(0,0,0,0,0,  0, 0,0,0,0,0,0,0);
`endif
    add(1,2,0,0,0,  5, 0,0,0,0,0,0,0);
    add(0,0,1,3,0,  5, 0,0,0,1,0,0,0);   // too little credit
    add(1,3,0,0,0, 15, 0,0,0,0,0,0,0);
    add(1,3,0,0,0, 25, 0,0,0,0,0,0,0);
    add(1,3,0,0,0, 35, 0,0,0,0,0,0,0);
    add(1,3,0,0,0, 45, 0,0,0,0,0,0,0);
    add(1,3,0,0,0, 45, 0,0,1,0,0,0,0);   // would exceed ceiling
    add(1,2,0,0,0, 50, 0,0,0,0,0,0,0);   // exactly at ceiling
    add(1,0,0,0,0, 50, 0,0,1,0,0,0,0);
    add(1,0,1,3,0, 30, 1,3,1,0,0,0,1);   // select wins, coin refused
`ifdef VEND_CHANGE_EN
    add(1,0,0,0,0, 20, 0,0,1,0,1,3,1);   // coin during vend refused
    add(0,0,0,0,0, 10, 0,0,0,0,1,3,1);
    add(0,0,0,0,0,  0, 0,0,0,0,1,3,1);
    add(0,0,0,0,0,  0, 0,0,0,0,0,0,0);
`else
    add(1,0,0,0,0, 30, 0,0,1,0,0,0,0);
    add(0,0,1,3,0, 10, 1,3,0,0,0,0,1);
    add(0,0,0,0,0, 10, 0,0,0,0,0,0,0);
    add(0,0,1,1,0,  0, 1,1,0,0,0,0,1);
    add(0,0,0,0,0,  0, 0,0,0,0,0,0,0);
`endif
    add(1,2,0,0,0,  5, 0,0,0,0,0,0,0);
    add(1,1,0,0,0,  7, 0,0,0,0,0,0,0);
`ifdef VEND_CHANGE_EN
    add(1,0,1,0,1,  2, 0,0,1,0,1,2,1);   // cancel beats select and coin
    add(1,3,1,0,1,  0, 0,0,1,0,1,1,1);   // inputs during change
    add(0,0,0,0,0,  0, 0,0,0,0,0,0,0);
`else
    add(1,0,1,0,1,  2, 1,0,1,0,0,0,1);   // cancel ignored, select wins
    add(0,0,0,0,0,  2, 0,0,0,0,0,0,0);
    add(0,0,0,0,1,  2, 0,0,0,0,0,0,0);
    add(0,0,1,0,0,  2, 0,0,0,1,0,0,0);
    add(1,0,0,0,0,  3, 0,0,0,0,0,0,0);
`endif

    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", obs, 17'h0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cv, vecs[i].ct, vecs[i].sv, vecs[i].s, vecs[i].cn);
      step();
      check($sformatf("vec%0d", i), obs,
            {vecs[i].credit, vecs[i].disp, vecs[i].id, vecs[i].rej, vecs[i].den,
             vecs[i].chv, vecs[i].cht, vecs[i].busy});
    end
    drive(0, 0, 0, 0, 0);

    // Reset asserted in the middle of a transaction.
    reset = 1'b0;
    step();
    reset = 1'b1;
    drive(1, 3, 0, 0, 0); step();
    drive(1, 3, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0); step();
    check("vend_15", obs, {8'd15, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1});
    drive(0, 0, 0, 0, 0); step();
`ifdef VEND_CHANGE_EN
    check("mid_change", obs, {8'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1});
`else
    check("remainder_kept", obs, {8'd15, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0});
`endif
    #2 reset = 1'b0;
    #1 check("async_reset", obs, 17'h0);
    step();
    reset = 1'b1;
    step();
    check("idle_after_reset", obs, 17'h0);
    drive(1, 0, 0, 0, 0); step();
    check("coin_after_reset", obs, {8'd1, 9'h0});
    drive(0, 0, 0, 0, 0); step();

`ifndef VEND_CHANGE_EN
    check("change_never", {16'h0, cv_seen}, 17'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
